stream_arbiter: RTL and testbench

- Shares one AXI-Stream master port between NUM_SRC snoop submodules (AR, AW, R, W, B channel streamers).
- Each submodule presents valid/in_progress/last/data and receives a ready.
- Grants one source at a time, round-robin, and holds the grant from first beat to the beat with last.
- Drives a registered output stage that tags each beat with the source index.

---
 rtl/stream_arbiter.sv | 141 ++++++++++++++
 tb/tb_stream_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_arbiter.sv
// Round-robin arbiter sharing one AXI-Stream master among NUM_SRC sources.
// A grant is held from the first beat of a packet to its last beat; beats are tagged with the source index.
module stream_arbiter #(
    parameter int unsigned NUM_SRC    = 5,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned SRC_W      = $clog2(NUM_SRC)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_SRC-1:0]              src_valid,
    input  logic [NUM_SRC-1:0]              src_in_progress,
    input  logic [NUM_SRC-1:0]              src_last,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_data,
    output logic [NUM_SRC-1:0]              src_ready,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    output logic [SRC_W-1:0]                m_axis_tid,
    input  logic                            m_axis_tready,
    output logic                            busy
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e                state_q, state_d;
    logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]      owner_q, owner_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic [SRC_W-1:0]      tid_q, tid_d;

    logic                  slot_free;
    logic [NUM_SRC-1:0]    eligible;
    logic [SRC_W-1:0]      winner;
    logic                  win_found;
    logic [SRC_W-1:0]      sel;
    logic                  grant_ok;
    logic                  accept;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;

    assign slot_free = !tvalid_q || m_axis_tready;

    // A pending burst wins outright; only the lowest-indexed in-progress source may resume.
    always_comb begin
        eligible = src_valid;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_in_progress[i]) begin
                eligible = src_valid & (NUM_SRC'(1) << i);
            end
        end
    end

    // Scan downwards so the candidate closest to rr_ptr is the one left standing.
    always_comb begin : p_winner
        int unsigned      idx;
        logic [SRC_W-1:0] idx_w;
        idx       = 0;
        idx_w     = '0;
        winner    = '0;
        win_found = 1'b0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = 32'(rr_ptr_q) + 32'(k);
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            idx_w = SRC_W'(idx);
            if (eligible[idx_w]) begin
                winner    = idx_w;
                win_found = 1'b1;
            end
        end
    end

    assign sel      = (state_q == StLocked) ? owner_q : winner;
    assign grant_ok = (state_q == StLocked) || win_found;

    always_comb begin
        src_ready = '0;
        if (!reset && slot_free && grant_ok) begin
            src_ready[sel] = 1'b1;
        end
    end

    assign accept   = |(src_valid & src_ready);
    assign sel_last = src_last[sel];
    assign sel_data = src_data[32'(sel) * DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;
        tid_d    = tid_q;
        if (accept) begin
            tvalid_d = 1'b1;
            tdata_d  = sel_data;
            tlast_d  = sel_last;
            tid_d    = sel;
            if (sel_last) begin
                state_d  = StIdle;
                rr_ptr_d = (32'(sel) == NUM_SRC - 1) ? '0 : sel + SRC_W'(1);
            end else begin
                state_d = StLocked;
                owner_d = sel;
            end
        end else if (m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            tid_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
            tid_q    <= tid_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tid    = tid_q;
    assign busy          = (state_q == StLocked);

endmodule

// File: tb/tb_stream_arbiter.sv
// Directed bench for stream_arbiter: reset, round-robin, burst locking, backpressure,
// in-progress priority and reset mid-burst.
module tb_stream_arbiter;

    localparam int unsigned N  = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = $clog2(N);

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      src_valid;
    logic [N-1:0]      src_in_progress;
    logic [N-1:0]      src_last;
    logic [N*DW-1:0]   src_data;
    logic [N-1:0]      src_ready;
    logic [DW-1:0]     m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic [SW-1:0]     m_axis_tid;
    logic              m_axis_tready;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stream_arbiter #(
        .NUM_SRC    (N),
        .DATA_WIDTH (DW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .src_valid       (src_valid),
        .src_in_progress (src_in_progress),
        .src_last        (src_last),
        .src_data        (src_data),
        .src_ready       (src_ready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tid      (m_axis_tid),
        .m_axis_tready   (m_axis_tready),
        .busy            (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] v);
        src_data[i*DW +: DW] = v;
    endtask

    task automatic test_reset();
        reset = 1'b1; src_valid = '1; src_last = '1; m_axis_tready = 1'b1;
        #1;
        n_cmp++; if (src_ready !== 5'b00000) begin n_err++;
            $display("FAIL reset_ready: got %b want 00000", src_ready); end
        step();
        src_valid = '0; src_last = '0;
        step();
        reset = 1'b0;
        #1;
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++;
            $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        n_cmp++; if (m_axis_tlast !== 1'b0) begin n_err++;
            $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
        n_cmp++; if (m_axis_tdata !== 32'h0) begin n_err++;
            $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
        n_cmp++; if (m_axis_tid !== 3'd0) begin n_err++;
            $display("FAIL reset_tid: got %0d want 0", m_axis_tid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++;
            $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_single();
        src_valid = 5'b00001; src_last = 5'b00001; set_data(0, 32'hA5);
        #1;
        n_cmp++; if (src_ready !== 5'b00001) begin n_err++;
            $display("FAIL single_ready: got %b want 00001", src_ready); end
        step();
        src_valid = '0; src_last = '0;
        n_cmp++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hA5 ||
                     m_axis_tlast !== 1'b1 || m_axis_tid !== 3'd0) begin n_err++;
            $display("FAIL single_beat: got v=%b d=%h l=%b id=%0d want v=1 d=a5 l=1 id=0",
                     m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tid); end
        step();
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++;
            $display("FAIL single_drain: got tvalid=%b want 0", m_axis_tvalid); end
    endtask

    task automatic test_round_robin();
        logic [SW-1:0] exp_id;
        logic [N-1:0]  exp_rdy;
        logic [DW-1:0] exp_d;
        src_valid = 5'b01010; src_last = 5'b11111;
        set_data(1, 32'h11); set_data(3, 32'h33);
        for (int k = 0; k < 4; k++) begin
            exp_id  = (k % 2 == 0) ? 3'd1 : 3'd3;
            exp_rdy = (k % 2 == 0) ? 5'b00010 : 5'b01000;
            exp_d   = (k % 2 == 0) ? 32'h11 : 32'h33;
            #1;
            n_cmp++; if (src_ready !== exp_rdy) begin n_err++;
                $display("FAIL rr_ready[%0d]: got %b want %b", k, src_ready, exp_rdy); end
            step();
            n_cmp++; if (m_axis_tvalid !== 1'b1 || m_axis_tid !== exp_id ||
                         m_axis_tdata !== exp_d) begin n_err++;
                $display("FAIL rr_beat[%0d]: got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                         k, m_axis_tvalid, m_axis_tid, m_axis_tdata, exp_id, exp_d); end
        end
        src_valid = '0; src_last = '0;
        step();
    endtask

    task automatic test_burst_lock();
        src_last = 5'b00001; set_data(0, 32'h0A);
        for (int b = 0; b < 4; b++) begin
            src_valid   = (b == 0) ? 5'b00100 : 5'b00101;
            src_last[2] = (b == 3);
            set_data(2, 32'h20 + 32'(b));
            #1;
            n_cmp++; if (src_ready !== 5'b00100) begin n_err++;
                $display("FAIL burst_ready[%0d]: got %b want 00100", b, src_ready); end
            if (b > 0) begin
                n_cmp++; if (busy !== 1'b1) begin n_err++;
                    $display("FAIL burst_busy[%0d]: got %b want 1", b, busy); end
            end
            step();
            n_cmp++; if (m_axis_tid !== 3'd2 || m_axis_tdata !== 32'h20 + 32'(b) ||
                         m_axis_tlast !== (b == 3)) begin n_err++;
                $display("FAIL burst_beat[%0d]: got id=%0d d=%h l=%b want id=2 d=%h l=%b",
                         b, m_axis_tid, m_axis_tdata, m_axis_tlast, 32'h20 + 32'(b), b == 3); end
        end
        src_valid = 5'b00001; src_last = 5'b00001;
        #1;
        n_cmp++; if (busy !== 1'b0 || src_ready !== 5'b00001) begin n_err++;
            $display("FAIL burst_release: got busy=%b rdy=%b want busy=0 rdy=00001",
                     busy, src_ready); end
        step();
        n_cmp++; if (m_axis_tid !== 3'd0 || m_axis_tdata !== 32'h0A) begin n_err++;
            $display("FAIL burst_next: got id=%0d d=%h want id=0 d=0000000a",
                     m_axis_tid, m_axis_tdata); end
        src_valid = '0; src_last = '0;
        step();
    endtask

    task automatic test_backpressure();
        src_valid = 5'b00010; src_last = '0; set_data(1, 32'h40);
        #1;
        n_cmp++; if (src_ready !== 5'b00010) begin n_err++;
            $display("FAIL bp_first_ready: got %b want 00010", src_ready); end
        step();
        n_cmp++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h40) begin n_err++;
            $display("FAIL bp_first: got v=%b d=%h want v=1 d=40", m_axis_tvalid, m_axis_tdata); end
        m_axis_tready = 1'b0; set_data(1, 32'h41);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (src_ready !== 5'b00000) begin n_err++;
                $display("FAIL bp_stall_ready[%0d]: got %b want 00000", c, src_ready); end
            step();
            n_cmp++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h40 ||
                         m_axis_tid !== 3'd1) begin n_err++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h id=%0d want v=1 d=40 id=1",
                         c, m_axis_tvalid, m_axis_tdata, m_axis_tid); end
        end
        m_axis_tready = 1'b1;
        #1;
        n_cmp++; if (src_ready !== 5'b00010) begin n_err++;
            $display("FAIL bp_resume_ready: got %b want 00010", src_ready); end
        step();
        n_cmp++; if (m_axis_tdata !== 32'h41 || m_axis_tlast !== 1'b0) begin n_err++;
            $display("FAIL bp_beat1: got d=%h l=%b want d=41 l=0", m_axis_tdata, m_axis_tlast); end
        set_data(1, 32'h42); src_last = 5'b00010;
        step();
        n_cmp++; if (m_axis_tdata !== 32'h42 || m_axis_tlast !== 1'b1) begin n_err++;
            $display("FAIL bp_beat2: got d=%h l=%b want d=42 l=1", m_axis_tdata, m_axis_tlast); end
        src_valid = '0; src_last = '0;
        step();
        n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++;
            $display("FAIL bp_no_dup: got tvalid=%b want 0", m_axis_tvalid); end
    endtask

    task automatic test_in_progress();
        // Single beat from source 4 moves rr_ptr back to 0.
        src_valid = 5'b10000; src_last = 5'b10000; set_data(4, 32'h4F);
        step();
        src_valid = '0; src_last = '0;
        step();
        src_in_progress = 5'b00100; src_valid = 5'b00011; src_last = 5'b00011;
        #1;
        n_cmp++; if (src_ready !== 5'b00000) begin n_err++;
            $display("FAIL ip_not_valid: got %b want 00000", src_ready); end
        src_in_progress = 5'b10000; src_valid = 5'b10011; src_last = 5'b10011;
        set_data(4, 32'h44);
        #1;
        n_cmp++; if (src_ready !== 5'b10000) begin n_err++;
            $display("FAIL ip_ready: got %b want 10000", src_ready); end
        step();
        n_cmp++; if (m_axis_tid !== 3'd4 || m_axis_tdata !== 32'h44) begin n_err++;
            $display("FAIL ip_beat: got id=%0d d=%h want id=4 d=44", m_axis_tid, m_axis_tdata); end
        src_in_progress = '0; src_valid = '0; src_last = '0;
        step();
    endtask

    task automatic test_reset_mid_burst();
        src_valid = 5'b01000; src_last = 5'b01000; set_data(3, 32'h33);
        step();
        src_valid = 5'b00100; src_last = '0; set_data(2, 32'h60);
        step();
        n_cmp++; if (busy !== 1'b1) begin n_err++;
            $display("FAIL rst_burst_busy: got %b want 1", busy); end
        set_data(2, 32'h61); reset = 1'b1;
        #1;
        n_cmp++; if (src_ready !== 5'b00000) begin n_err++;
            $display("FAIL rst_burst_ready: got %b want 00000", src_ready); end
        step();
        reset = 1'b0; src_valid = '0;
        #1;
        n_cmp++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin n_err++;
            $display("FAIL rst_burst_state: got v=%b busy=%b want v=0 busy=0",
                     m_axis_tvalid, busy); end
        src_valid = 5'b10010; src_last = 5'b10010;
        set_data(1, 32'h71); set_data(4, 32'h74);
        #1;
        n_cmp++; if (src_ready !== 5'b00010) begin n_err++;
            $display("FAIL rst_rr_ready: got %b want 00010", src_ready); end
        step();
        n_cmp++; if (m_axis_tvalid !== 1'b1 || m_axis_tid !== 3'd1 ||
                     m_axis_tdata !== 32'h71) begin n_err++;
            $display("FAIL rst_rr_beat: got v=%b id=%0d d=%h want v=1 id=1 d=71",
                     m_axis_tvalid, m_axis_tid, m_axis_tdata); end
        src_valid = '0; src_last = '0;
        step();
    endtask

    initial begin
        reset = 1'b1; src_valid = '0; src_in_progress = '0; src_last = '0;
        src_data = '0; m_axis_tready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_burst_lock();
        test_backpressure();
        test_in_progress();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
